lab3_mem_mem_req_arbiter: RTL and testbench
===========================================

# lab3_mem_mem_req_arbiter

Shares a single cache-line memory port between two blocking caches: port 0 is the instruction cache and port 1 is the data cache. Requests are arbitrated round-robin with zero added latency. The source of each issued request is recorded in an in-order tracking queue. Memory responses, which return in issue order, are routed back to the port that issued the matching request. The block sits between the two cache controllers' refill/evict ports and the memory model or network.

## Interface

- p_req_nbits, 175: memory request message width (type 3, opaque 8, addr 32, len 4, data 128).
- p_resp_nbits, 145: memory response message width (type 3, opaque 8, test 2, len 4, data 128).
- p_max_outstanding, 4: tracking-queue depth; must be a power of two and at least 2.

Ports:

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req0_val / req0_rdy  in / out  1 / 1  port-0 request handshake.
- req0_msg  in  p_req_nbits  port-0 request message.
- req1_val / req1_rdy  in / out  1 / 1  port-1 request handshake.
- req1_msg  in  p_req_nbits  port-1 request message.
- resp0_val / resp0_rdy  out / in  1 / 1  port-0 response handshake.
- resp1_val / resp1_rdy  out / in  1 / 1  port-1 response handshake.
- resp_msg  out  p_resp_nbits  response message, driven to both response ports.
- memreq_val / memreq_rdy  out / in  1 / 1  memory request handshake.
- memreq_msg  out  p_req_nbits  memory request message (the granted port's request).
- memresp_val / memresp_rdy  in / out  1 / 1  memory response handshake.
- memresp_msg  in  p_resp_nbits  memory response message.

## Operation

**State**
- prio: 1 bit; the port that wins a tie.
- Tracking queue: p_max_outstanding entries of 1 bit (source id), with wr_ptr, rd_ptr and count. count is clog2(p_max_outstanding)+1 bits wide. Pointers wrap modulo the depth.
- full = (count == p_max_outstanding); empty = (count == 0).

**Request path** (combinational)
- Grant:
  - Both ports valid: grant goes to the port equal to prio.
  - One port valid: grant goes to that port.
  - No port valid: no grant.
- memreq_val = (req0_val | req1_val) & ~full. memreq_val must not depend on memreq_rdy.
- memreq_msg = the granted port's msg. When nothing is granted, drive req0_msg.
- reqN_rdy = grant==N & memreq_rdy & ~full. The losing port's rdy is 0.
- On a fire (memreq_val & memreq_rdy):
  - the granted id is pushed at wr_ptr;
  - prio <= ~granted id.
- With no fire, prio holds.
- Messages pass through unmodified; the opaque field is not rewritten.

**Response path** (combinational)
- head = queue[rd_ptr].
- resp0_val = memresp_val & ~empty & head==0.
- resp1_val = memresp_val & ~empty & head==1.
- memresp_rdy = ~empty & (head==0 ? resp0_rdy : resp1_rdy).
- resp_msg = memresp_msg.
- On a fire (memresp_val & memresp_rdy), pop.

**Boundary conditions**
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at any non-full count.
- When full, memreq_val is 0 even if a pop fires that cycle; there is no full bypass.
- When empty, memresp_rdy is 0. memresp_val=1 while empty is a protocol error; it is flagged by a simulation-only assertion and the response is not consumed.
- A stalled response port back-pressures memory and does not block the request path until the queue is full.

**Reset**
- While reset is 0: prio=0, pointers=0, count=0.
- All outputs are forced low: every *_val and *_rdy output is 0.
- Assertion mid-transaction discards all outstanding tracking immediately, without waiting for a clock edge. Any later stray memory response is then an error.

## Timing

- Arbitration adds zero cycles: request-in to memreq is combinational, and memresp to resp is combinational.
- Throughput is one request and one response per cycle.
- Tracking and prio update on the rising edge after a fire.
- A valid request held with memreq_rdy=1 and the queue not full is granted within 2 cycles.
- After deassertion of reset, the first grant on a tie goes to port 0.

## Test plan

- **Single port:** port 0 issues addr 0x1000, memory responds one cycle later. Required: memreq carries the 0x1000 msg in the same cycle; resp0_val=1 and resp1_val=0 with the response data.
- **Tie round-robin:** both ports valid continuously and memreq_rdy=1. Required grants: 0,1,0,1. Each granted port's rdy=1 only in its own cycle.
- **Ordering:** issue p0 (opaque 0x11), then p1 (0x22), then p1 (0x33). Memory returns the responses in order. Required: resp0 receives 0x11, then resp1 receives 0x22, then resp1 receives 0x33.
- **Full:** issue 4 requests with no responses. Required: count=4 and memreq_val=0 on the 5th request. A response and a new request in the same cycle produce a pop only; the request is issued the next cycle.
- **Back-pressure:** head=p1 with resp1_rdy=0 and memresp_val=1. Required: memresp_rdy=0 and resp1_val=1 held; port 0 requests continue to issue while count<4.
- **Reset mid-flight:** 2 requests outstanding, then reset pulled to 0 asynchronously between edges. Required: all val/rdy outputs go to 0 immediately, and after release count=0 and prio=0.

Source files
------------

// File: rtl/lab3_mem_mem_req_arbiter_if.sv
// Valid/ready/message channel shared by the request and response sides of the arbiter.
// master drives val/msg and samples rdy; slave samples val/msg and drives rdy.
interface lab3_mem_mem_req_arbiter_if #(
  parameter int p_nbits = 8
);
  logic               val;
  logic               rdy;
  logic [p_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/lab3_mem_mem_req_arbiter.sv
// Two-port round-robin arbiter for a shared cache-line memory port.
// Port 0 is the instruction cache, port 1 the data cache. Each issued request
// records its source in an in-order tracking queue so in-order memory responses
// can be steered back to the issuing cache. Request and response paths are
// purely combinational; only prio and the tracking queue are stateful.
// p_max_outstanding must be a power of two and at least 2 so the pointers wrap
// naturally.
module lab3_mem_mem_req_arbiter #(
  parameter int p_req_nbits       = 175,
  parameter int p_resp_nbits      = 145,
  parameter int p_max_outstanding = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  lab3_mem_mem_req_arbiter_if.slave  req0,
  lab3_mem_mem_req_arbiter_if.slave  req1,
  lab3_mem_mem_req_arbiter_if.master resp0,
  lab3_mem_mem_req_arbiter_if.master resp1,
  lab3_mem_mem_req_arbiter_if.master memreq,
  lab3_mem_mem_req_arbiter_if.slave  memresp
);

  localparam int ptr_w = $clog2(p_max_outstanding);
  localparam int cnt_w = ptr_w + 1;

  logic                         prio;
  logic [p_max_outstanding-1:0] track_q;
  logic [ptr_w-1:0]             wr_ptr;
  logic [ptr_w-1:0]             rd_ptr;
  logic [cnt_w-1:0]             count;

  logic                    full;
  logic                    empty;
  logic                    gnt_any;
  logic                    gnt_id;
  logic                    head;
  logic                    memreq_val;
  logic                    memresp_rdy;
  logic                    req_fire;
  logic                    resp_fire;
  logic [p_req_nbits-1:0]  req_msg_mux;
  logic [p_resp_nbits-1:0] resp_msg;

  assign full  = (count == cnt_w'(p_max_outstanding));
  assign empty = (count == '0);

  // Grant selection: a tie goes to prio, a lone requester always wins.
  always_comb begin
    gnt_any = req0.val | req1.val;
    if (req0.val && req1.val) begin
      gnt_id = prio;
    end else begin
      gnt_id = req1.val;
    end
  end

  // Every handshake output is gated by reset so outputs drop the moment reset
  // is asserted, not at the next edge.
  assign memreq_val  = reset & gnt_any & ~full;
  assign req_msg_mux = gnt_id ? req1.msg : req0.msg;
  assign memreq.val  = memreq_val;
  assign memreq.msg  = req_msg_mux;
  assign req0.rdy    = memreq_val & ~gnt_id & memreq.rdy;
  assign req1.rdy    = memreq_val &  gnt_id & memreq.rdy;
  assign req_fire    = memreq_val & memreq.rdy;

  assign head        = track_q[rd_ptr];
  assign resp_msg    = memresp.msg;
  assign resp0.val   = reset & memresp.val & ~empty & ~head;
  assign resp1.val   = reset & memresp.val & ~empty &  head;
  assign resp0.msg   = resp_msg;
  assign resp1.msg   = resp_msg;
  assign memresp_rdy = reset & ~empty & (head ? resp1.rdy : resp0.rdy);
  assign memresp.rdy = memresp_rdy;
  assign resp_fire   = memresp.val & memresp_rdy;

  // Priority flip and tracking-queue pointers/occupancy; reset discards all tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (req_fire) begin
        prio   <= ~gnt_id;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (resp_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({req_fire, resp_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Source-id storage; entries are only meaningful between push and pop, so no reset.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      track_q[wr_ptr] <= gnt_id;
    end
  end

  // A memory response with nothing outstanding is a protocol error.
  stray_resp_chk: assert property (@(posedge clk) disable iff (!reset) !(memresp.val && empty));

endmodule

// File: tb/tb_lab3_mem_mem_req_arbiter.sv
// Directed bench for the two-port memory request arbiter with a scoreboard:
// stimulus queues the expected memory requests and per-port responses, and a
// monitor branch pops and compares them whenever a handshake fires.
module tb_lab3_mem_mem_req_arbiter;
  localparam int req_w  = 175;
  localparam int resp_w = 145;

  typedef struct {
    logic             port;
    logic [req_w-1:0] msg;
  } req_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lab3_mem_mem_req_arbiter_if #(.p_nbits(req_w))  req0();
  lab3_mem_mem_req_arbiter_if #(.p_nbits(req_w))  req1();
  lab3_mem_mem_req_arbiter_if #(.p_nbits(req_w))  memreq();
  lab3_mem_mem_req_arbiter_if #(.p_nbits(resp_w)) resp0();
  lab3_mem_mem_req_arbiter_if #(.p_nbits(resp_w)) resp1();
  lab3_mem_mem_req_arbiter_if #(.p_nbits(resp_w)) memresp();

  lab3_mem_mem_req_arbiter #(
    .p_req_nbits(req_w), .p_resp_nbits(resp_w), .p_max_outstanding(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .resp0(resp0), .resp1(resp1),
    .memreq(memreq), .memresp(memresp)
  );

  req_exp_t          exp_req[$];
  logic [resp_w-1:0] exp_resp0[$];
  logic [resp_w-1:0] exp_resp1[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [req_w-1:0] mk_req(logic [7:0] op, logic [31:0] addr, logic [127:0] data);
    return {3'd0, op, addr, 4'd0, data};
  endfunction

  function automatic logic [resp_w-1:0] mk_resp(logic [7:0] op, logic [127:0] data);
    return {3'd0, op, 2'd0, 4'd0, data};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_issue(input logic port, input logic [req_w-1:0] msg);
    req_exp_t e;
    e.port = port;
    e.msg  = msg;
    exp_req.push_back(e);
  endtask

  task automatic monitor();
    req_exp_t          e;
    logic [resp_w-1:0] r;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (memreq.val && memreq.rdy) begin
          n_cmp++;
          if (exp_req.size() == 0) begin
            n_bad++;
            $display("FAIL memreq_fire: unexpected issue port1_rdy=%0d msg=%0h", req1.rdy, memreq.msg);
          end else begin
            e = exp_req.pop_front();
            if (memreq.msg !== e.msg || req1.rdy !== e.port || req0.rdy !== !e.port) begin
              n_bad++;
              $display("FAIL memreq_fire: got rdy0=%0d rdy1=%0d msg=%0h expected port=%0d msg=%0h",
                       req0.rdy, req1.rdy, memreq.msg, e.port, e.msg);
            end
          end
        end
        if (resp0.val && resp0.rdy) begin
          n_cmp++;
          if (exp_resp0.size() == 0) begin
            n_bad++;
            $display("FAIL resp0_fire: unexpected response msg=%0h", resp0.msg);
          end else begin
            r = exp_resp0.pop_front();
            if (resp0.msg !== r || resp1.val !== 1'b0) begin
              n_bad++;
              $display("FAIL resp0_fire: got msg=%0h resp1_val=%0d expected msg=%0h resp1_val=0",
                       resp0.msg, resp1.val, r);
            end
          end
        end
        if (resp1.val && resp1.rdy) begin
          n_cmp++;
          if (exp_resp1.size() == 0) begin
            n_bad++;
            $display("FAIL resp1_fire: unexpected response msg=%0h", resp1.msg);
          end else begin
            r = exp_resp1.pop_front();
            if (resp1.msg !== r || resp0.val !== 1'b0) begin
              n_bad++;
              $display("FAIL resp1_fire: got msg=%0h resp0_val=%0d expected msg=%0h resp0_val=0",
                       resp1.msg, resp0.val, r);
            end
          end
        end
      end
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_memreq_val"}, 32'(memreq.val), 0);
    check({tag, "_req0_rdy"}, 32'(req0.rdy), 0);
    check({tag, "_req1_rdy"}, 32'(req1.rdy), 0);
    check({tag, "_resp0_val"}, 32'(resp0.val), 0);
    check({tag, "_resp1_val"}, 32'(resp1.val), 0);
    check({tag, "_memresp_rdy"}, 32'(memresp.rdy), 0);
  endtask

  task automatic stimulus();
    logic [req_w-1:0] m0;
    logic [req_w-1:0] m1;
    req0.val = 0; req0.msg = '0;
    req1.val = 0; req1.msg = '0;
    memreq.rdy = 1;
    memresp.val = 0; memresp.msg = '0;
    resp0.rdy = 1; resp1.rdy = 1;
    reset = 0;
    #2;
    req0.val = 1; req1.val = 1; memresp.val = 1;
    #1;
    check_all_low("reset");
    req0.val = 0; req1.val = 0; memresp.val = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1;

    // tie round-robin, first tie after reset goes to port 0; fills the queue
    for (int k = 0; k < 4; k++) begin
      step();
      m0 = mk_req(8'h10 + 8'(k), 32'h2000 + 32'(k * 64), 128'hA0 + 128'(k));
      m1 = mk_req(8'h20 + 8'(k), 32'h3000 + 32'(k * 64), 128'hB0 + 128'(k));
      req0.val = 1; req0.msg = m0;
      req1.val = 1; req1.msg = m1;
      exp_issue(k[0], k[0] ? m1 : m0);
    end
    // full: nothing issues
    step();
    #2;
    check("full_memreq_val", 32'(memreq.val), 0);
    check("full_req0_rdy", 32'(req0.rdy), 0);
    check("full_req1_rdy", 32'(req1.rdy), 0);
    // full with a response and a request in the same cycle: pop only
    step();
    req1.val = 0;
    m0 = mk_req(8'h40, 32'h4000, 128'hC0);
    req0.msg = m0;
    memresp.val = 1; memresp.msg = mk_resp(8'h10, 128'hD0);
    exp_resp0.push_back(memresp.msg);
    #2;
    check("full_pop_memreq_val", 32'(memreq.val), 0);
    check("full_pop_memresp_rdy", 32'(memresp.rdy), 1);
    // request goes out the next cycle together with the next pop
    step();
    memresp.msg = mk_resp(8'h21, 128'hD1);
    exp_resp1.push_back(memresp.msg);
    exp_issue(1'b0, m0);
    #2;
    check("after_pop_memreq_val", 32'(memreq.val), 1);
    step();
    req0.val = 0;
    memresp.msg = mk_resp(8'h12, 128'hD2);
    exp_resp0.push_back(memresp.msg);
    // back-pressure: head is port 1 and port 1 is stalled
    step();
    resp1.rdy = 0;
    memresp.msg = mk_resp(8'h23, 128'hD3);
    m0 = mk_req(8'h41, 32'h4100, 128'hC1);
    req0.val = 1; req0.msg = m0;
    exp_issue(1'b0, m0);
    #2;
    check("bp_memresp_rdy", 32'(memresp.rdy), 0);
    check("bp_resp1_val", 32'(resp1.val), 1);
    check("bp_resp0_val", 32'(resp0.val), 0);
    step();
    m0 = mk_req(8'h42, 32'h4200, 128'hC2);
    req0.msg = m0;
    exp_issue(1'b0, m0);
    #2;
    check("bp2_memresp_rdy", 32'(memresp.rdy), 0);
    check("bp2_resp1_val", 32'(resp1.val), 1);
    step();
    req0.msg = mk_req(8'h43, 32'h4300, 128'hC3);
    #2;
    check("bp_full_memreq_val", 32'(memreq.val), 0);
    step();
    req0.val = 0;
    resp1.rdy = 1;
    exp_resp1.push_back(memresp.msg);
    for (int j = 0; j < 3; j++) begin
      step();
      memresp.msg = mk_resp(8'h40 + 8'(j), 128'hE0 + 128'(j));
      exp_resp0.push_back(memresp.msg);
    end
    // drained; ordering test p0 0x11, p1 0x22, p1 0x33
    step();
    memresp.val = 0;
    m0 = mk_req(8'h11, 32'h5000, 128'hF0);
    req0.val = 1; req0.msg = m0;
    exp_issue(1'b0, m0);
    #2;
    check("empty_memresp_rdy", 32'(memresp.rdy), 0);
    step();
    req0.val = 0;
    m1 = mk_req(8'h22, 32'h5040, 128'hF1);
    req1.val = 1; req1.msg = m1;
    exp_issue(1'b1, m1);
    step();
    m1 = mk_req(8'h33, 32'h5080, 128'hF2);
    req1.msg = m1;
    exp_issue(1'b1, m1);
    memresp.val = 1; memresp.msg = mk_resp(8'h11, 128'h111);
    exp_resp0.push_back(memresp.msg);
    step();
    req1.val = 0;
    memresp.msg = mk_resp(8'h22, 128'h222);
    exp_resp1.push_back(memresp.msg);
    step();
    memresp.msg = mk_resp(8'h33, 128'h333);
    exp_resp1.push_back(memresp.msg);
    // single port, addr 0x1000
    step();
    memresp.val = 0;
    m0 = mk_req(8'h01, 32'h1000, 128'h5A5A);
    req0.val = 1; req0.msg = m0;
    exp_issue(1'b0, m0);
    #2;
    check("single_memreq_addr", memreq.msg[163:132], 32'h1000);
    step();
    req0.val = 0;
    memresp.val = 1; memresp.msg = mk_resp(8'h01, 128'hDEADBEEF);
    exp_resp0.push_back(memresp.msg);
    #2;
    check("single_resp0_val", 32'(resp0.val), 1);
    check("single_resp1_val", 32'(resp1.val), 0);
    // two outstanding, prio is 1 after the last port-0 issue
    step();
    memresp.val = 0;
    m0 = mk_req(8'h50, 32'h6000, 128'h50);
    m1 = mk_req(8'h60, 32'h7000, 128'h60);
    req0.val = 1; req0.msg = m0;
    req1.val = 1; req1.msg = m1;
    exp_issue(1'b1, m1);
    step();
    m0 = mk_req(8'h51, 32'h6040, 128'h51);
    m1 = mk_req(8'h61, 32'h7040, 128'h61);
    req0.msg = m0; req1.msg = m1;
    exp_issue(1'b0, m0);
    // reset mid-flight, between edges
    step();
    req0.msg = mk_req(8'h52, 32'h6080, 128'h52);
    req1.msg = mk_req(8'h62, 32'h7080, 128'h62);
    memresp.val = 1; memresp.msg = mk_resp(8'h60, 128'h600);
    #2 reset = 0;
    #1;
    check_all_low("midrst");
    req0.val = 0; req1.val = 0; memresp.val = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1;
    #1;
    check("rel_memresp_rdy", 32'(memresp.rdy), 0);
    step();
    m0 = mk_req(8'h70, 32'h8000, 128'h70);
    m1 = mk_req(8'h80, 32'h9000, 128'h80);
    req0.val = 1; req0.msg = m0;
    req1.val = 1; req1.msg = m1;
    exp_issue(1'b0, m0);
    step();
    m0 = mk_req(8'h71, 32'h8040, 128'h71);
    m1 = mk_req(8'h81, 32'h9040, 128'h81);
    req0.msg = m0; req1.msg = m1;
    exp_issue(1'b1, m1);
    step();
    req0.val = 0; req1.val = 0;
    memresp.val = 1; memresp.msg = mk_resp(8'h70, 128'h700);
    exp_resp0.push_back(memresp.msg);
    step();
    memresp.msg = mk_resp(8'h81, 128'h810);
    exp_resp1.push_back(memresp.msg);
    step();
    memresp.val = 0;
    repeat (3) step();
    check("left_memreq", 32'(exp_req.size()), 0);
    check("left_resp0", 32'(exp_resp0.size()), 0);
    check("left_resp1", 32'(exp_resp1.size()), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
